// File: rtl/rom_dl_pkg.sv
// Shared types and region-table helpers for the ROM download router.
// The default region table matches the 8-region game build.
package rom_dl_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} dl_state_t;

  localparam int MAX_REGIONS = 32;
  localparam int MAX_AW      = 32;

  typedef logic [MAX_AW-1:0]             rom_addr_t;
  typedef logic [MAX_REGIONS*MAX_AW-1:0] end_tbl_t;

  localparam int GAME_NUM_REGIONS = 8;
  localparam int GAME_ADDR_W      = 25;
  localparam logic [GAME_NUM_REGIONS*GAME_ADDR_W-1:0] GAME_REGION_END = {
    25'h60000, 25'h50000, 25'h40000, 25'h38000,
    25'h30000, 25'h28000, 25'h20000, 25'h10000
  };

  // Tables are packed with region 0 in the least significant aw bits.
  function automatic rom_addr_t region_end(input end_tbl_t ends, input int aw, input int i);
    end_tbl_t  sh;
    rom_addr_t mask;
    sh   = ends >> (i * aw);
    mask = (aw >= MAX_AW) ? '1 : ((rom_addr_t'(1) << aw) - rom_addr_t'(1));
    return sh[MAX_AW-1:0] & mask;
  endfunction

  function automatic rom_addr_t region_base(input end_tbl_t ends, input int aw, input int i);
    return (i == 0) ? '0 : region_end(ends, aw, i - 1);
  endfunction

endpackage

// File: rtl/rom_dl_router_if.sv
// ioctl download stream in, per-region RAM write port and status out.
// master is the HPS/ioctl side, slave is the router.
interface rom_dl_router_if #(
  parameter int NUM_REGIONS = 8,
  parameter int ADDR_W      = 25,
  parameter int LOCAL_AW    = 16,
  parameter int DATA_W      = 8
);
  logic                   ioctl_download;
  logic [7:0]             ioctl_index;
  logic                   ioctl_wr;
  logic [ADDR_W-1:0]      ioctl_addr;
  logic [DATA_W-1:0]      ioctl_dout;
  logic [NUM_REGIONS-1:0] dl_cs;
  logic [LOCAL_AW-1:0]    dl_addr;
  logic [DATA_W-1:0]      dl_data;
  logic                   dl_we;
  logic [NUM_REGIONS-1:0] region_full;
  logic [15:0]            oor_count;
  logic                   rom_ready;
  logic                   dl_error;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  dl_cs, dl_addr, dl_data, dl_we, region_full, oor_count, rom_ready, dl_error
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output dl_cs, dl_addr, dl_data, dl_we, region_full, oor_count, rom_ready, dl_error
  );
endinterface

// File: rtl/rom_region_decode.sv
// Combinational lowest-match region decoder over an ascending end-address table.
// Zero latency, no backpressure; also flags the last byte of the matched region.
module rom_region_decode
  import rom_dl_pkg::*;
#(
  parameter int NUM_REGIONS = GAME_NUM_REGIONS,
  parameter int ADDR_W      = GAME_ADDR_W,
  parameter int LOCAL_AW    = 16,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_END = GAME_REGION_END,
  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic              last,
  output logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] base
);

  localparam end_tbl_t ENDS = end_tbl_t'(REGION_END);

  logic [ADDR_W-1:0] end_a  [NUM_REGIONS];
  logic [ADDR_W-1:0] base_a [NUM_REGIONS];

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_rgn
    localparam rom_addr_t END_V  = region_end(ENDS, ADDR_W, g);
    localparam rom_addr_t BASE_V = region_base(ENDS, ADDR_W, g);
    if (END_V < BASE_V) begin : g_bad_order
      $error("rom_region_decode: REGION_END not ascending at region %0d", g);
    end else if ((64'(END_V) - 64'(BASE_V)) > (64'd1 << LOCAL_AW)) begin : g_bad_size
      $error("rom_region_decode: region %0d larger than 2^LOCAL_AW", g);
    end
    assign end_a[g]  = END_V[ADDR_W-1:0];
    assign base_a[g] = BASE_V[ADDR_W-1:0];
  end

  // Descending scan so the lowest matching region wins; empty regions never match.
  always_comb begin
    hit  = 1'b0;
    last = 1'b0;
    idx  = '0;
    base = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (addr < end_a[i]) begin
        hit  = 1'b1;
        last = (addr == end_a[i] - ADDR_W'(1));
        idx  = IDX_W'(i);
        base = base_a[i];
      end
    end
  end

endmodule

// File: rtl/rom_dl_router.sv
// Routes ioctl byte writes to per-region ROM RAMs and tracks download completion.
// 2-cycle latency ioctl_wr -> dl_we, one write per cycle, never stalls.
module rom_dl_router
  import rom_dl_pkg::*;
#(
  parameter int NUM_REGIONS = GAME_NUM_REGIONS,
  parameter int ADDR_W      = GAME_ADDR_W,
  parameter int LOCAL_AW    = 16,
  parameter int DATA_W      = 8,
  parameter logic [7:0] ROM_INDEX = 8'd0,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_END = GAME_REGION_END
) (
  input logic            CLK,
  input logic            RESET,
  rom_dl_router_if.slave bus
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam end_tbl_t ENDS = end_tbl_t'(REGION_END);

  if (NUM_REGIONS < 1 || NUM_REGIONS > MAX_REGIONS || ADDR_W > MAX_AW) begin : g_bad_cfg
    $error("rom_dl_router: unsupported NUM_REGIONS/ADDR_W");
  end

  function automatic logic [NUM_REGIONS-1:0] zero_mask();
    logic [NUM_REGIONS-1:0] m;
    for (int i = 0; i < NUM_REGIONS; i++)
      m[i] = (region_end(ENDS, ADDR_W, i) == region_base(ENDS, ADDR_W, i));
    return m;
  endfunction

  // Empty regions can never be written, so they start every download already full.
  localparam logic [NUM_REGIONS-1:0] ZERO_MASK = zero_mask();

  logic active, active_q, rise, accept;
  dl_state_t state;

  assign active = bus.ioctl_download & (bus.ioctl_index == ROM_INDEX);
  assign rise   = active & ~active_q;
  assign accept = bus.ioctl_wr & active & ((state == LOAD) | rise);

  logic              d_hit, d_last;
  logic [IDX_W-1:0]  d_idx;
  logic [ADDR_W-1:0] d_base;

  rom_region_decode #(
    .NUM_REGIONS(NUM_REGIONS),
    .ADDR_W     (ADDR_W),
    .LOCAL_AW   (LOCAL_AW),
    .REGION_END (REGION_END)
  ) u_decode (
    .addr(bus.ioctl_addr),
    .hit (d_hit),
    .last(d_last),
    .idx (d_idx),
    .base(d_base)
  );

  logic              s1_vld, s1_hit, s1_last;
  logic [IDX_W-1:0]  s1_idx;
  logic [ADDR_W-1:0] s1_addr, s1_base;
  logic [DATA_W-1:0] s1_data;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_vld  <= 1'b0;
      s1_hit  <= 1'b0;
      s1_last <= 1'b0;
      s1_idx  <= '0;
      s1_addr <= '0;
      s1_base <= '0;
      s1_data <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_hit  <= d_hit;
        s1_last <= d_last;
        s1_idx  <= d_idx;
        s1_addr <= bus.ioctl_addr;
        s1_base <= d_base;
        s1_data <= bus.ioctl_dout;
      end
    end
  end

  logic                   dl_we;
  logic [NUM_REGIONS-1:0] dl_cs;
  logic [LOCAL_AW-1:0]    dl_addr;
  logic [DATA_W-1:0]      dl_data;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dl_we   <= 1'b0;
      dl_cs   <= '0;
      dl_addr <= '0;
      dl_data <= '0;
    end else begin
      dl_we   <= s1_vld & s1_hit;
      dl_cs   <= (s1_vld & s1_hit) ? (NUM_REGIONS'(1) << s1_idx) : '0;
      dl_addr <= LOCAL_AW'(s1_addr - s1_base);
      dl_data <= s1_data;
    end
  end

  logic [NUM_REGIONS-1:0] region_full;
  logic [15:0]            oor_count;
  logic                   rom_ready, dl_error;

  // active_q resets high so a download still asserted at reset release is not a new start.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      active_q    <= 1'b1;
      region_full <= '0;
      oor_count   <= '0;
      rom_ready   <= 1'b0;
      dl_error    <= 1'b0;
    end else begin
      active_q <= active;
      if (s1_vld & s1_hit & s1_last)
        region_full[s1_idx] <= 1'b1;
      if (s1_vld & ~s1_hit & (oor_count != 16'hFFFF))
        oor_count <= oor_count + 16'd1;

      if (rise && state != LOAD) begin
        state       <= LOAD;
        region_full <= ZERO_MASK;
        oor_count   <= '0;
        rom_ready   <= 1'b0;
        dl_error    <= 1'b0;
      end else begin
        case (state)
          LOAD:    if (!active) state <= FLUSH;
          FLUSH: begin
            if (!s1_vld && !dl_we) begin
              state     <= DONE;
              rom_ready <= &region_full;
              dl_error  <= ~&region_full;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.dl_we       = dl_we;
  assign bus.dl_cs       = dl_cs;
  assign bus.dl_addr     = dl_addr;
  assign bus.dl_data     = dl_data;
  assign bus.region_full = region_full;
  assign bus.oor_count   = oor_count;
  assign bus.rom_ready   = rom_ready;
  assign bus.dl_error    = dl_error;

endmodule
